printer: RTL and testbench
==========================

# printer

Parameterized character-stream message source. After reset it emits one fixed ASCII line, "printer_<ID>\n", over a valid/ready byte stream and then signals completion. The line can be replayed on request. Instances printer_0, printer_1, printer_10 (and further IDs) are this block with ID fixed to the suffix number. The block sits under the top-level harness as one of many parallel banner sources feeding a shared console/log sink.

## Interface
- ID, default 0: printer number embedded in the message; legal range 0..99.
- AUTO_START, default 1: 1 = send the line automatically after reset release; 0 = wait for start.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle request to (re)send the line; sampled only in IDLE or DONE.
- char_data  out  8  ASCII byte currently offered.
- char_valid  out  1  char_data is valid.
- char_ready  in  1  sink accepts the byte when high together with char_valid.
- busy  out  1  high while the line is being sent.
- done  out  1  level; high after the last byte ('\n') is accepted, until the next start.

## Operation
- Message: "printer_", then ID in decimal with no leading zero, then 0x0A.
  - ID 0..9 gives 10 bytes.
  - ID 10..99 gives 11 bytes.
  - Digits: tens = ID/10, ones = ID%10, each encoded as 0x30 + digit. Computed at elaboration.
  - Message length MSG_LEN = 10 + (ID >= 10).
- FSM states: IDLE, SEND, DONE.
  - Reset enters SEND if AUTO_START=1, else IDLE.
  - IDLE: start leads to SEND with index 0.
  - SEND: a byte transfers when char_valid && char_ready, and the index increments. A transfer of index MSG_LEN-1 leads to DONE.
  - DONE: start leads to SEND with index 0.
  - start is ignored while in SEND.
- Outputs:
  - char_valid = (state == SEND).
  - char_data = message byte at the current index. It is 0x00 when not in SEND.
  - busy = (state == SEND).
  - done = (state == DONE).
- Handshake:
  - char_data and char_valid are held stable while char_valid && !char_ready.
  - char_valid is never withdrawn before a transfer.
  - char_ready may be low indefinitely; there is no timeout.
- ID out of range (> 99): elaboration error.

## Timing
- Reset values while rst is high: char_valid=0, char_data=0x00, busy=0, done=0, index=0. These are asserted asynchronously.
- All outputs are registered or decoded from registered state. There is no combinational path from char_ready or start to any output.
- AUTO_START=1:
  - char_valid rises at the first rising edge after rst falls (cycle 1).
  - With char_ready held high, one byte transfers per cycle: cycles 1..MSG_LEN.
  - done rises in cycle MSG_LEN+1.
- A start sampled at edge N gives char_valid=1 from cycle N+1.
- Reset asserted mid-line aborts immediately. After release the line restarts from index 0, per AUTO_START.
- If start and rst are asserted together, reset wins.

## Structure
- Package printer_pkg holds:
  - state enum {IDLE, SEND, DONE};
  - PREFIX constant "printer_" (8 bytes);
  - ASCII_0 = 8'h30 and ASCII_LF = 8'h0A;
  - MSG_MAX_LEN = 11 and index width 4.
- Sub-module printer_msg_rom(ID): combinational index-to-byte lookup, with the digit split done at elaboration.
- The top module holds the FSM, index counter and output registers.
- printer_0, printer_1 and printer_10 are thin wrappers instantiating printer with ID=0, 1 and 10 respectively. They have identical ports.

## Test plan
- printer_0, AUTO_START=1, char_ready=1:
  - bytes 70 72 69 6E 74 65 72 5F 30 0A are sent in cycles 1..10;
  - done=1 from cycle 11, busy=0.
- printer_10, char_ready=1:
  - 11 bytes ending 5F 31 30 0A;
  - done in cycle 12;
  - printer_1 ends 5F 31 0A (10 bytes).
- Backpressure: char_ready low for 3 cycles at index 4.
  - char_data holds 0x74 and char_valid holds 1 throughout;
  - there are no dropped or duplicated bytes;
  - total duration is 13 cycles.
- Replay: pulse start while in DONE.
  - The identical line resends from 0x70.
  - A start pulsed mid-SEND has no effect.
- Reset at index 6 mid-line:
  - outputs clear asynchronously to 0;
  - after release the line restarts at 0x70.
- AUTO_START=0: nothing is sent after reset until start; then the line is sent as in the first scenario.

Source files
------------

// File: rtl/printer_pkg.sv
// Shared types and constants for the printer banner source.
// Message layout: "printer_" + decimal ID + LF.
package printer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam int unsigned IDX_W       = 4;
    localparam int unsigned MSG_MAX_LEN = 11;

    localparam logic [63:0] PREFIX   = "printer_";
    localparam logic [7:0]  ASCII_0  = 8'h30;
    localparam logic [7:0]  ASCII_LF = 8'h0A;

    function automatic int unsigned msg_len(input int unsigned id);
        return (id >= 10) ? 11 : 10;
    endfunction

endpackage

// File: rtl/printer_0.sv
// Banner source instance with ID 0.
module printer_0 #(
    parameter bit AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    printer #(.ID(0), .AUTO_START(AUTO_START)) u_printer (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

endmodule

// File: rtl/printer_1.sv
// Banner source instance with ID 1.
module printer_1 #(
    parameter bit AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    printer #(.ID(1), .AUTO_START(AUTO_START)) u_printer (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

endmodule

// File: rtl/printer_10.sv
// Banner source instance with ID 10.
module printer_10 #(
    parameter bit AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    printer #(.ID(10), .AUTO_START(AUTO_START)) u_printer (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done)
    );

endmodule

// File: rtl/printer_msg_rom.sv
// Index-to-byte lookup for the fixed banner line.
// Digits are resolved from ID at elaboration time.
module printer_msg_rom
    import printer_pkg::*;
#(
    parameter int unsigned ID = 0
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [7:0]       o_byte
);

    localparam logic [7:0] TENS = ASCII_0 + 8'(ID / 10);
    localparam logic [7:0] ONES = ASCII_0 + 8'(ID % 10);
    localparam bit         TWO  = (ID >= 10);

    always_comb begin
        o_byte = 8'h00;
        if (i_idx < 4'd8) begin
            o_byte = PREFIX[8*(7-int'(i_idx)) +: 8];
        end else if (TWO) begin
            case (i_idx)
                4'd8:    o_byte = TENS;
                4'd9:    o_byte = ONES;
                4'd10:   o_byte = ASCII_LF;
                default: o_byte = 8'h00;
            endcase
        end else begin
            case (i_idx)
                4'd8:    o_byte = ONES;
                4'd9:    o_byte = ASCII_LF;
                default: o_byte = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/printer.sv
// Banner source: streams "printer_<ID>\n" over a valid/ready byte link.
// FSM, index counter and output decode live here.
module printer
    import printer_pkg::*;
#(
    parameter int unsigned ID         = 0,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       char_ready,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       busy,
    output logic       done
);

    if (ID > 99) begin : g_id_chk
        $error("printer: ID must be in 0..99");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(msg_len(ID) - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_auto;
    logic [7:0]       w_rom_byte;
    logic             w_send;

    printer_msg_rom #(.ID(ID)) u_rom (
        .i_idx  (r_idx),
        .o_byte (w_rom_byte)
    );

    // r_auto launches the first line one edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_auto  <= AUTO_START;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_auto  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (r_auto || start) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                end
            end
            SEND: begin
                if (char_ready) begin
                    if (r_idx == LAST) begin
                        w_state_nxt = DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_send     = (r_state == SEND);
    assign char_valid = w_send;
    assign busy       = w_send;
    assign done       = (r_state == DONE);
    assign char_data  = w_send ? w_rom_byte : 8'h00;

endmodule

// File: tb/tb_printer.sv
// Self-checking bench for the printer banner source.
module tb_printer;

    typedef struct {
        logic       rdy;
        logic       st;
        logic       v;
        logic [7:0] d;
        logic       b;
        logic       dn;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rdy0, st0, st10, st1, rdya, sta, one;
    logic [7:0] d0, d10, d1, da;
    logic       v0, b0, dn0, v10, b10, dn10, v1, b1, dn1, va, ba, dna;

    printer #(.ID(0), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .start(st0), .char_ready(rdy0),
        .char_data(d0), .char_valid(v0), .busy(b0), .done(dn0)
    );
    printer_10 u10 (
        .clk(clk), .rst(rst), .start(st10), .char_ready(one),
        .char_data(d10), .char_valid(v10), .busy(b10), .done(dn10)
    );
    printer_1 u1 (
        .clk(clk), .rst(rst), .start(st1), .char_ready(one),
        .char_data(d1), .char_valid(v1), .busy(b1), .done(dn1)
    );
    printer #(.ID(0), .AUTO_START(1'b0)) ua (
        .clk(clk), .rst(rst), .start(sta), .char_ready(rdya),
        .char_data(da), .char_valid(va), .busy(ba), .done(dna)
    );

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int cyc = 0;
    int dn10_at = 0;
    int dn1_at = 0;
    bit rec = 1'b0;
    bit va_seen = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] qa[$];
    logic [7:0] got10[$];
    logic [7:0] got1[$];
    logic [7:0] m0[10];
    logic [7:0] m10[11];
    logic [7:0] m1[10];
    vec_t vec1[$];
    vec_t vec2[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push_msg0();
        for (int i = 0; i < 10; i++) q0.push_back(m0[i]);
    endtask

    task automatic apply(input vec_t t, input string tag);
        logic [7:0] e;
        rdy0 = t.rdy;
        st0  = t.st;
        #1;
        chk({tag, "_valid"}, 32'(v0), 32'(t.v));
        chk({tag, "_data"}, 32'(d0), 32'(t.d));
        chk({tag, "_busy"}, 32'(b0), 32'(t.b));
        chk({tag, "_done"}, 32'(dn0), 32'(t.dn));
        if (v0) vcnt++;
        if (v0 && rdy0) begin
            if (q0.size() == 0) begin
                chk({tag, "_sb_extra"}, 32'(d0), 32'hFFFF);
            end else begin
                e = q0.pop_front();
                chk({tag, "_sb"}, 32'(d0), 32'(e));
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) cyc = 0;
        else cyc++;
        if (rec && !rst) begin
            if (v10) got10.push_back(d10);
            if (v1) got1.push_back(d1);
            if (dn10 && dn10_at == 0) dn10_at = cyc;
            if (dn1 && dn1_at == 0) dn1_at = cyc;
            if (va) va_seen = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        m0  = '{8'h70, 8'h72, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h72,
                8'h5F, 8'h30, 8'h0A};
        m1  = '{8'h70, 8'h72, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h72,
                8'h5F, 8'h31, 8'h0A};
        m10 = '{8'h70, 8'h72, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h72,
                8'h5F, 8'h31, 8'h30, 8'h0A};

        for (int i = 0; i < 10; i++)
            vec1.push_back('{1'b1, 1'b0, 1'b1, m0[i], 1'b1, 1'b0});
        for (int i = 0; i < 2; i++)
            vec1.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});

        vec2.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        for (int i = 0; i < 10; i++) begin
            if (i == 4)
                for (int k = 0; k < 3; k++)
                    vec2.push_back('{1'b0, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0});
            vec2.push_back('{1'b1, (i == 2), 1'b1, m0[i], 1'b1, 1'b0});
        end
        for (int i = 0; i < 2; i++)
            vec2.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});

        rst = 1'b1; rdy0 = 1'b0; st0 = 1'b0; st10 = 1'b0; st1 = 1'b0;
        rdya = 1'b1; sta = 1'b0; one = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_data", 32'(d0), 32'h0);
        chk("rst_busy", 32'(b0), 32'h0);
        chk("rst_done", 32'(dn0), 32'h0);

        // auto start, full-rate line
        rec = 1'b1;
        #1 rst = 1'b0;
        push_msg0();
        @(negedge clk);
        foreach (vec1[i]) apply(vec1[i], "auto");
        rec = 1'b0;
        chk("p10_len", 32'(got10.size()), 32'd11);
        foreach (m10[i])
            if (i < got10.size()) chk("p10_byte", 32'(got10[i]), 32'(m10[i]));
        chk("p10_done_cyc", 32'(dn10_at), 32'd12);
        chk("p1_len", 32'(got1.size()), 32'd10);
        foreach (m1[i])
            if (i < got1.size()) chk("p1_byte", 32'(got1[i]), 32'(m1[i]));
        chk("p1_done_cyc", 32'(dn1_at), 32'd11);
        chk("noauto_quiet", 32'(va_seen), 32'h0);

        // replay with backpressure and an ignored mid-line start
        push_msg0();
        vcnt = 0;
        foreach (vec2[i]) apply(vec2[i], "bp");
        chk("bp_cycles", 32'(vcnt), 32'd13);
        chk("bp_sb_left", 32'(q0.size()), 32'd0);

        // reset at index 6
        push_msg0();
        apply('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1}, "rr_start");
        for (int i = 0; i < 6; i++)
            apply('{1'b1, 1'b0, 1'b1, m0[i], 1'b1, 1'b0}, "rr_pre");
        #1;
        chk("rr_idx6_data", 32'(d0), 32'h72);
        #1 rst = 1'b1;
        #1;
        chk("rr_async_valid", 32'(v0), 32'h0);
        chk("rr_async_data", 32'(d0), 32'h0);
        chk("rr_async_busy", 32'(b0), 32'h0);
        chk("rr_async_done", 32'(dn0), 32'h0);
        chk("rr_sb_left", 32'(q0.size()), 32'd4);
        q0.delete();
        st0 = 1'b1;
        sta = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rr_hold_valid", 32'(v0), 32'h0);
        got10.delete();
        got1.delete();
        va_seen = 1'b0;
        rec = 1'b1;
        #1 rst = 1'b0;
        st0 = 1'b0;
        sta = 1'b0;
        push_msg0();
        @(negedge clk);
        foreach (vec1[i]) apply(vec1[i], "rr_post");
        rec = 1'b0;
        chk("start_rst_quiet", 32'(va_seen), 32'h0);
        chk("noauto_idle_done", 32'(dna), 32'h0);

        // AUTO_START=0 line after explicit start
        sta = 1'b1;
        for (int i = 0; i < 10; i++) qa.push_back(m0[i]);
        @(negedge clk);
        sta = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("na_valid", 32'(va), 32'h1);
            if (va && rdya && qa.size() != 0) begin
                e = qa.pop_front();
                chk("na_sb", 32'(da), 32'(e));
            end
            @(negedge clk);
        end
        #1;
        chk("na_done", 32'(dna), 32'h1);
        chk("na_end_valid", 32'(va), 32'h0);
        chk("na_sb_left", 32'(qa.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
